// File: rtl/adder_pipe_if.sv
// Handshake and data bundle for adder_pipe.
// The master drives operands and output-ready; the slave is the adder itself.
interface adder_pipe_if #(
    parameter int WIDTH = 16,
    parameter int LANES = 1
);
    logic                         i_valid;
    logic                         o_ready;
    logic [LANES*WIDTH-1:0]       i_a;
    logic [LANES*WIDTH-1:0]       i_b;
    logic                         i_mode;
    logic                         i_clear;
    logic                         o_valid;
    logic                         i_ready;
    logic [LANES*(WIDTH+1)-1:0]   o_sum;
    logic [LANES-1:0]             o_sat;

    modport master (
        output i_valid, i_a, i_b, i_mode, i_clear, i_ready,
        input  o_ready, o_valid, o_sum, o_sat
    );

    modport slave (
        input  i_valid, i_a, i_b, i_mode, i_clear, i_ready,
        output o_ready, o_valid, o_sum, o_sat
    );
endinterface

// File: rtl/adder_pipe.sv
// Multi-lane pipelined adder with a per-lane saturating accumulate mode.
// Stage 0 does the arithmetic; later stages are plain delay registers.
module adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int LANES  = 1,
    parameter int STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_pipe_if.slave bus
);
    localparam int SW = WIDTH + 1;

    logic [STAGES-1:0]               vld_q;
    logic [STAGES-1:0][LANES*SW-1:0] sum_q;
    logic [STAGES-1:0][LANES-1:0]    sat_q;
    logic [LANES-1:0][SW-1:0]        acc_q;
    logic [LANES-1:0][SW-1:0]        acc_d;
    logic [LANES-1:0]                flag_q;
    logic [LANES-1:0]                flag_d;
    logic [LANES*SW-1:0]             sum_d;
    logic [LANES-1:0]                sat_d;
    logic [STAGES-1:0]               stageLoad;
    logic                            accept;

    // A stage may load if it or any stage downstream of it has a hole, or the output drains.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            stageLoad[s] = bus.i_ready;
            for (int t = s; t < STAGES; t++) begin
                if (!vld_q[t]) begin
                    stageLoad[s] = 1'b1;
                end
            end
        end
    end

    assign accept      = bus.i_valid & stageLoad[0];
    assign bus.o_ready = stageLoad[0];
    assign bus.o_valid = vld_q[STAGES-1];
    assign bus.o_sum   = sum_q[STAGES-1];
    assign bus.o_sat   = sat_q[STAGES-1];

    always_comb begin
        logic [SW-1:0]    base;
        logic             baseFlag;
        logic [SW:0]      nxt;
        logic [WIDTH-1:0] laneA;
        logic [WIDTH-1:0] laneB;
        acc_d  = acc_q;
        flag_d = flag_q;
        sum_d  = '0;
        sat_d  = '0;
        for (int k = 0; k < LANES; k++) begin
            laneA    = bus.i_a[k*WIDTH +: WIDTH];
            laneB    = bus.i_b[k*WIDTH +: WIDTH];
            // Clear takes effect before the beat, so the beat sees a zero accumulator.
            base     = bus.i_clear ? '0 : acc_q[k];
            baseFlag = bus.i_clear ? 1'b0 : flag_q[k];
            nxt      = '0;
            if (bus.i_mode) begin
                nxt = {1'b0, base} + {2'b00, laneA};
                if (nxt[SW]) begin
                    acc_d[k]  = '1;
                    flag_d[k] = 1'b1;
                end else begin
                    acc_d[k]  = nxt[SW-1:0];
                    flag_d[k] = baseFlag;
                end
                sum_d[k*SW +: SW] = acc_d[k];
            end else begin
                sum_d[k*SW +: SW] = {1'b0, laneA} + {1'b0, laneB};
                acc_d[k]          = base;
                flag_d[k]         = baseFlag;
            end
            sat_d[k] = flag_d[k];
        end
    end

    // Accumulators move only on an accepted beat, so stalls never re-add.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            sum_q  <= '0;
            sat_q  <= '0;
            acc_q  <= '0;
            flag_q <= '0;
        end else begin
            if (accept) begin
                acc_q  <= acc_d;
                flag_q <= flag_d;
            end
            if (stageLoad[0]) begin
                vld_q[0] <= bus.i_valid;
                if (bus.i_valid) begin
                    sum_q[0] <= sum_d;
                    sat_q[0] <= sat_d;
                end
            end
            for (int s = 1; s < STAGES; s++) begin
                if (stageLoad[s]) begin
                    vld_q[s] <= vld_q[s-1];
                    if (vld_q[s-1]) begin
                        sum_q[s] <= sum_q[s-1];
                        sat_q[s] <= sat_q[s-1];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: a 4-lane 2-stage instance plus
// single-lane 1-stage and 8-stage instances for latency and stall streams.
module tb_adder_pipe;
    logic clk;
    logic rst_n;
    int   testsRun;
    int   testsFailed;

    adder_pipe_if #(.WIDTH(16), .LANES(4)) ifA ();
    adder_pipe_if #(.WIDTH(16), .LANES(1)) ifS1 ();
    adder_pipe_if #(.WIDTH(16), .LANES(1)) ifS8 ();

    adder_pipe #(.WIDTH(16), .LANES(4), .STAGES(2)) dutA  (.clk(clk), .rst_n(rst_n), .bus(ifA));
    adder_pipe #(.WIDTH(16), .LANES(1), .STAGES(1)) dutS1 (.clk(clk), .rst_n(rst_n), .bus(ifS1));
    adder_pipe #(.WIDTH(16), .LANES(1), .STAGES(8)) dutS8 (.clk(clk), .rst_n(rst_n), .bus(ifS8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] accA   [5] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h1234};
    logic [16:0] expSum [5] = '{17'h0FFFF, 17'h17FFF, 17'h1FFFE, 17'h1FFFF, 17'h1FFFF};
    logic        expSat [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] a, input logic [63:0] b,
                                 input logic m, input logic c, input logic r);
        ifA.i_valid = v;
        ifA.i_a     = a;
        ifA.i_b     = b;
        ifA.i_mode  = m;
        ifA.i_clear = c;
        ifA.i_ready = r;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [67:0] expLanes;
        logic [67:0] heldSum;
        logic        stalledPrev;
        logic        rdy;
        logic        r1;
        logic        r8;
        int          sent;
        int          got;
        int          inFlight;
        int          latS1;
        int          latS8;
        int          gotS1;
        int          gotS8;
        int          sentS1;
        int          sentS8;
        logic [16:0] sumS1;
        logic [16:0] sumS8;

        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        applyStimulus(0, 64'h0, 64'h0, 0, 0, 1);
        ifS1.i_valid = 0; ifS1.i_a = '0; ifS1.i_b = '0; ifS1.i_mode = 0; ifS1.i_clear = 0; ifS1.i_ready = 1;
        ifS8.i_valid = 0; ifS8.i_a = '0; ifS8.i_b = '0; ifS8.i_mode = 0; ifS8.i_clear = 0; ifS8.i_ready = 1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        checkOutput("rst_valid", ifA.o_valid, 0);
        checkOutput("rst_sum", ifA.o_sum, 0);
        checkOutput("rst_sat", ifA.o_sat, 0);
        checkOutput("rst_s8_valid", ifS8.o_valid, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_ready", ifA.o_ready, 1);
        cycle();

        // Single add: 0xFFFF + 1 with two-cycle latency
        applyStimulus(1, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 0, 0, 1);
        #1;
        checkOutput("add_ready", ifA.o_ready, 1);
        cycle();
        applyStimulus(0, 64'h0, 64'h0, 0, 0, 1);
        checkOutput("add_lat1_valid", ifA.o_valid, 0);
        cycle();
        checkOutput("add_valid", ifA.o_valid, 1);
        checkOutput("add_sum", ifA.o_sum, 68'h10000);
        checkOutput("add_sat", ifA.o_sat, 0);
        cycle();
        checkOutput("add_drained", ifA.o_valid, 0);

        // Four lanes in one beat
        applyStimulus(1, {16'hFFFF, 16'h0000, 16'h8000, 16'h0001},
                         {16'hFFFF, 16'h0000, 16'h8000, 16'h0002}, 0, 0, 1);
        cycle();
        applyStimulus(0, 64'h0, 64'h0, 0, 0, 1);
        cycle();
        expLanes = {17'h1FFFE, 17'h00000, 17'h10000, 17'h00003};
        checkOutput("lanes_valid", ifA.o_valid, 1);
        checkOutput("lanes_sum", ifA.o_sum, expLanes);
        cycle();

        // Accumulate to saturation, then add beats observing the sticky flag
        applyStimulus(1, 64'hFFFF, 64'h0, 1, 1, 1);
        cycle();
        applyStimulus(1, 64'hFFFF, 64'h0, 1, 0, 1);
        cycle();
        checkOutput("acc1_sum", ifA.o_sum, 68'h0FFFF);
        checkOutput("acc1_sat", ifA.o_sat, 4'b0000);
        applyStimulus(1, 64'h0005, 64'h0, 1, 0, 1);
        cycle();
        checkOutput("acc2_sum", ifA.o_sum, 68'h1FFFE);
        checkOutput("acc2_sat", ifA.o_sat, 4'b0000);
        applyStimulus(1, 64'h0001, 64'h0001, 0, 0, 1);
        cycle();
        checkOutput("acc3_sum", ifA.o_sum, 68'h1FFFF);
        checkOutput("acc3_sat", ifA.o_sat, 4'b0001);
        applyStimulus(1, 64'h0001, 64'h0002, 0, 1, 1);
        cycle();
        checkOutput("addsat_sum", ifA.o_sum, 68'h2);
        checkOutput("addsat_sat", ifA.o_sat, 4'b0001);
        applyStimulus(1, 64'h0007, 64'h0, 1, 0, 1);
        cycle();
        checkOutput("clradd_sum", ifA.o_sum, 68'h3);
        checkOutput("clradd_sat", ifA.o_sat, 4'b0000);
        applyStimulus(0, 64'h0, 64'h0, 0, 0, 1);
        cycle();
        checkOutput("postclr_acc", ifA.o_sum, 68'h7);
        checkOutput("postclr_valid", ifA.o_valid, 1);
        cycle();

        // Backpressure: ten accumulate beats of 1, i_ready alternating
        sent = 0; got = 0; inFlight = 0; stalledPrev = 0; heldSum = '0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            rdy = (cyc % 2 == 0);
            applyStimulus(sent < 10, 64'h1, 64'h0, 1, sent == 0, rdy);
            #1;
            checkOutput("bp_ready", ifA.o_ready, !(inFlight == 2 && !rdy));
            if (stalledPrev) checkOutput("bp_hold", ifA.o_sum, heldSum);
            stalledPrev = ifA.o_valid && !rdy;
            heldSum     = ifA.o_sum;
            if (ifA.o_valid && rdy) begin
                checkOutput($sformatf("bp_order%0d", got), ifA.o_sum, 68'(got + 1));
                got++;
                inFlight--;
            end
            if (ifA.i_valid && ifA.o_ready) begin
                sent++;
                inFlight++;
            end
            cycle();
        end
        checkOutput("bp_count", got, 10);
        applyStimulus(0, 64'h0, 64'h0, 0, 0, 1);
        cycle();

        // Reset with two beats in flight drops them
        applyStimulus(1, 64'h1, 64'h0, 1, 1, 1);
        cycle();
        applyStimulus(1, 64'h1, 64'h0, 1, 0, 1);
        cycle();
        rst_n = 1'b0;
        applyStimulus(0, 64'h0, 64'h0, 0, 0, 1);
        cycle();
        checkOutput("midrst_valid", ifA.o_valid, 0);
        checkOutput("midrst_sum", ifA.o_sum, 0);
        rst_n = 1'b1;
        applyStimulus(1, 64'h3, 64'h0, 1, 0, 1);
        cycle();
        applyStimulus(0, 64'h0, 64'h0, 0, 0, 1);
        checkOutput("midrst_nodrain", ifA.o_valid, 0);
        cycle();
        checkOutput("midrst_acc_valid", ifA.o_valid, 1);
        checkOutput("midrst_acc_sum", ifA.o_sum, 68'h3);
        cycle();

        // Latency of the 1-stage and 8-stage instances
        ifS1.i_valid = 1; ifS1.i_a = 16'd10; ifS1.i_b = 16'd20;
        ifS8.i_valid = 1; ifS8.i_a = 16'd10; ifS8.i_b = 16'd20;
        cycle();
        ifS1.i_valid = 0;
        ifS8.i_valid = 0;
        latS1 = 0; latS8 = 0; sumS1 = '0; sumS8 = '0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (ifS1.o_valid && latS1 == 0) begin latS1 = cyc; sumS1 = ifS1.o_sum; end
            if (ifS8.o_valid && latS8 == 0) begin latS8 = cyc; sumS8 = ifS8.o_sum; end
            cycle();
        end
        checkOutput("s1_latency", latS1, 1);
        checkOutput("s8_latency", latS8, 8);
        checkOutput("s1_lat_sum", sumS1, 30);
        checkOutput("s8_lat_sum", sumS8, 30);

        // Accumulate stream with random i_ready on both instances
        gotS1 = 0; gotS8 = 0; sentS1 = 0; sentS8 = 0;
        for (int cyc = 0; cyc < 300 && (gotS1 < 5 || gotS8 < 5); cyc++) begin
            r1 = 1'($urandom_range(0, 1));
            r8 = 1'($urandom_range(0, 1));
            ifS1.i_valid = (sentS1 < 5); ifS1.i_a = (sentS1 < 5) ? accA[sentS1] : 16'h0;
            ifS1.i_mode  = 1; ifS1.i_clear = (sentS1 == 0); ifS1.i_ready = r1;
            ifS8.i_valid = (sentS8 < 5); ifS8.i_a = (sentS8 < 5) ? accA[sentS8] : 16'h0;
            ifS8.i_mode  = 1; ifS8.i_clear = (sentS8 == 0); ifS8.i_ready = r8;
            #1;
            if (ifS1.o_valid && r1 && gotS1 < 5) begin
                checkOutput($sformatf("s1_sum%0d", gotS1), ifS1.o_sum, expSum[gotS1]);
                checkOutput($sformatf("s1_sat%0d", gotS1), ifS1.o_sat, expSat[gotS1]);
                gotS1++;
            end
            if (ifS8.o_valid && r8 && gotS8 < 5) begin
                checkOutput($sformatf("s8_sum%0d", gotS8), ifS8.o_sum, expSum[gotS8]);
                checkOutput($sformatf("s8_sat%0d", gotS8), ifS8.o_sat, expSat[gotS8]);
                gotS8++;
            end
            if (ifS1.i_valid && ifS1.o_ready) sentS1++;
            if (ifS8.i_valid && ifS8.o_ready) sentS8++;
            cycle();
        end
        checkOutput("s1_count", gotS1, 5);
        checkOutput("s8_count", gotS8, 5);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
